instr_fetch_unit: RTL and testbench

//  Responder side of the PC fetch interface: consumes PCAddr/GetInstruction from PC and

---
 rtl/apcpu_pkg.sv | 13 +
 rtl/fetch_watchdog.sv | 32 +++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apcpu_pkg.sv
// Shared fetch-path definitions: FSM encodings, word geometry and default timeout.
package apcpu_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_READ = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES     = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage : apcpu_pkg

// File: rtl/fetch_watchdog.sv
// Memory wait counter: counts stalled READ cycles and flags the cycle that hits TIMEOUT.
module fetch_watchdog
  import apcpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Stall counter; clear has priority, saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Terminal count: this stalled cycle is the TIMEOUT-th one.
  assign tc_c = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule : fetch_watchdog

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: assembles a big-endian word from four byte reads.
module instr_fetch_unit
  import apcpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned MEM_W   = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  PCAddr,
  input  logic               GetInstruction,
  input  logic               Flush,
  output logic [ADDR_W-1:0]  MemAddr,
  output logic               MemRead,
  input  logic [MEM_W-1:0]   MemData,
  input  logic               MemReady,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  output logic               Busy,
  output logic               FetchError
);

  localparam int unsigned IDX_W = $clog2(INSTR_BYTES);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [INSTR_W-1:0] asm_q, asm_d;
  logic               take_byte, last_byte, err;
  logic               wd_clr, wd_en, wd_tc_c;

  // Watchdog only runs while READ is genuinely stalled.
  assign wd_en  = (state_q == FETCH_READ) && !MemReady && !Flush;
  assign wd_clr = !wd_en;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc_c (wd_tc_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, base/index updates and event strobes.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    take_byte = 1'b0;
    last_byte = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (GetInstruction && !Flush) begin
          if (PCAddr[IDX_W-1:0] != '0) begin
            err = 1'b1;
          end else begin
            base_d  = PCAddr;
            idx_d   = '0;
            state_d = FETCH_READ;
          end
        end
      end
      FETCH_READ: begin
        if (Flush) begin
          state_d = FETCH_IDLE;
        end else if (MemReady) begin
          take_byte = 1'b1;
          if (idx_q == IDX_W'(INSTR_BYTES - 1)) begin
            last_byte = 1'b1;
            state_d   = FETCH_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (wd_tc_c) begin
          err     = 1'b1;
          state_d = FETCH_IDLE;
        end
      end
      FETCH_DONE: begin
        state_d = FETCH_IDLE;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  // Insert the incoming byte at its big-endian lane (index 0 is the MSB).
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        asm_d[INSTR_W-1-i*MEM_W -: MEM_W] = MemData;
      end
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      MemAddr     <= '0;
      MemRead     <= 1'b0;
      Busy        <= 1'b0;
      Instruction <= '0;
      InstrValid  <= 1'b0;
      FetchError  <= 1'b0;
    end else begin
      base_q     <= base_d;
      idx_q      <= idx_d;
      MemAddr    <= base_d + ADDR_W'(idx_d);
      MemRead    <= (state_d == FETCH_READ);
      Busy       <= (state_d != FETCH_IDLE);
      InstrValid <= last_byte;
      FetchError <= err;
      if (take_byte) begin
        asm_q <= asm_d;
      end
      if (last_byte) begin
        Instruction <= asm_d;
      end
    end
  end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand-written corner sequences.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] PCAddr;
  logic        GetInstruction;
  logic        Flush;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [7:0]  MemData;
  logic        MemReady;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Busy;
  logic        FetchError;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .PCAddr         (PCAddr),
    .GetInstruction (GetInstruction),
    .Flush          (Flush),
    .MemAddr        (MemAddr),
    .MemRead        (MemRead),
    .MemData        (MemData),
    .MemReady       (MemReady),
    .Instruction    (Instruction),
    .InstrValid     (InstrValid),
    .Busy           (Busy),
    .FetchError     (FetchError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory contents
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_16A0: return 8'h12;
      32'h0000_16A1: return 8'h34;
      32'h0000_16A2: return 8'h56;
      32'h0000_16A3: return 8'h78;
      32'h0000_0020: return 8'hDE;
      32'h0000_0021: return 8'hAD;
      32'h0000_0022: return 8'hBE;
      32'h0000_0023: return 8'hEF;
      32'h0000_1EC8: return 8'hA1;
      32'h0000_1EC9: return 8'hB2;
      32'h0000_1ECA: return 8'hC3;
      32'h0000_1ECB: return 8'hD4;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_comb MemData = mem_byte(MemAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch with 'gap' low-MemReady cycles before every byte; latencies counted in edges after edge N.
  task automatic run_fetch(input logic [31:0] a, input int gap, output int lat_v, output int lat_e,
                           output int nreads, output int bad_addr, output int busy_bad);
    int w, nb, lim;
    logic rd;
    lat_v = -1; lat_e = -1; nreads = 0; bad_addr = 0; busy_bad = 0;
    w = 0; nb = 0; lim = 80;
    PCAddr = a; GetInstruction = 1'b1; MemReady = 1'b0;
    tick();
    GetInstruction = 1'b0;
    if (FetchError) begin
      lat_e = 0;
      lim   = 3;
    end
    for (int k = 1; k <= lim; k++) begin
      rd = MemRead;
      if (rd) begin
        nreads++;
        if (MemAddr !== a + 32'(nb)) bad_addr++;
        MemReady = (w >= gap);
      end else begin
        MemReady = 1'b0;
      end
      tick();
      if (rd) begin
        if (MemReady) begin nb++; w = 0; end
        else w++;
      end
      if (lat_e == 0) continue;
      if (InstrValid) begin
        lat_v = k;
        if (!Busy) busy_bad++;
        break;
      end
      if (FetchError) begin
        lat_e = k;
        break;
      end
      if (!Busy) busy_bad++;
    end
    MemReady = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          gap;
    int          lat_v;
    int          lat_e;
    logic [31:0] instr;
    int          nreads;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lv, le, nr, ba, bb, evs;
    vecs[0] = '{32'h0000_16A0, 0,  4, -1, 32'h1234_5678,  4};
    vecs[1] = '{32'h0000_169F, 0, -1,  0, 32'h1234_5678,  0};
    vecs[2] = '{32'h0000_16A0, 3, 16, -1, 32'h1234_5678, 16};
    vecs[3] = '{32'h0000_0020, 0,  4, -1, 32'hDEAD_BEEF,  4};
    vecs[4] = '{32'h0000_0020, 15, -1, 15, 32'hDEAD_BEEF, 15};
    vecs[5] = '{32'h0000_1EC8, 1,  8, -1, 32'hA1B2_C3D4,  8};
    vecs[6] = '{32'h0000_1EC6, 0, -1,  0, 32'hA1B2_C3D4,  0};
    vecs[7] = '{32'h0000_0020, 14, 60, -1, 32'hDEAD_BEEF, 60};

    rst = 1'b1; PCAddr = '0; GetInstruction = 1'b0; Flush = 1'b0; MemReady = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {31'd0, MemRead, 31'd0, Busy, 31'd0, InstrValid, 31'd0, FetchError}, 32'd0);
    chk("reset_memaddr", MemAddr, 32'd0);
    chk("reset_instr", Instruction, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven fetches
    for (int i = 0; i < 8; i++) begin
      run_fetch(vecs[i].addr, vecs[i].gap, lv, le, nr, ba, bb);
      chk($sformatf("v%0d_valid_lat", i), 32'(lv), 32'(vecs[i].lat_v));
      chk($sformatf("v%0d_error_lat", i), 32'(le), 32'(vecs[i].lat_e));
      chk($sformatf("v%0d_instr", i), Instruction, vecs[i].instr);
      chk($sformatf("v%0d_reads", i), 32'(nr), 32'(vecs[i].nreads));
      chk($sformatf("v%0d_addr_seq", i), 32'(ba), 32'd0);
      chk($sformatf("v%0d_busy", i), 32'(bb), 32'd0);
      chk($sformatf("v%0d_memread_end", i), {31'd0, MemRead}, 32'd0);
      tick();
      tick();
    end

    // Load a known word, then flush a fetch at 0x1EC8 after two bytes
    run_fetch(32'h0000_16A0, 0, lv, le, nr, ba, bb);
    tick();
    tick();
    PCAddr = 32'h0000_1EC8; GetInstruction = 1'b1;
    tick();
    GetInstruction = 1'b0; MemReady = 1'b1;
    tick();
    tick();
    chk("flush_addr_before", MemAddr, 32'h0000_1ECA);
    Flush = 1'b1;
    tick();
    Flush = 1'b0; MemReady = 1'b0;
    chk("flush_memread", {31'd0, MemRead}, 32'd0);
    chk("flush_busy", {31'd0, Busy}, 32'd0);
    evs = 0;
    for (int k = 0; k < 6; k++) begin
      if (InstrValid || FetchError) evs++;
      tick();
    end
    chk("flush_no_pulses", 32'(evs), 32'd0);
    chk("flush_instr_kept", Instruction, 32'h1234_5678);
    run_fetch(32'h0000_0020, 0, lv, le, nr, ba, bb);
    chk("after_flush_lat", 32'(lv), 32'd4);
    chk("after_flush_instr", Instruction, 32'hDEAD_BEEF);
    tick();
    tick();

    // Flush together with a request in IDLE drops the request
    PCAddr = 32'h0000_16A0; GetInstruction = 1'b1; Flush = 1'b1;
    tick();
    GetInstruction = 1'b0; Flush = 1'b0;
    evs = 0;
    for (int k = 0; k < 4; k++) begin
      if (MemRead || Busy || FetchError || InstrValid) evs++;
      tick();
    end
    chk("idle_flush_dropped", 32'(evs), 32'd0);

    // Reset in the middle of a fetch
    PCAddr = 32'h0000_16A0; GetInstruction = 1'b1;
    tick();
    GetInstruction = 1'b0; MemReady = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; MemReady = 1'b0;
    chk("midrst_flags", {28'd0, MemRead, Busy, InstrValid, FetchError}, 32'd0);
    chk("midrst_instr", Instruction, 32'd0);
    chk("midrst_memaddr", MemAddr, 32'd0);
    tick();

    // Request held while Busy must not start a second fetch
    PCAddr = 32'h0000_16A0; GetInstruction = 1'b1; MemReady = 1'b1;
    tick();
    PCAddr = 32'h0000_0020;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("busy_req_addr%0d", k), MemAddr, 32'h0000_16A0 + 32'(k));
      tick();
    end
    GetInstruction = 1'b0; MemReady = 1'b0;
    chk("busy_req_valid", {31'd0, InstrValid}, 32'd1);
    chk("busy_req_instr", Instruction, 32'h1234_5678);
    tick();
    chk("busy_req_idle", {30'd0, Busy, InstrValid}, 32'd0);
    tick();
    chk("busy_req_no_second", {30'd0, MemRead, Busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
